// File: rtl/pc_redirect_unit.sv
// ---------------------------------------------------------------------------
// pc_redirect_unit
//
// Owns the program counter at the consumer end of the BEQ resolution path.
// A resolved branch arrives from EX as (Zero flag, PC+4, raw 16-bit offset).
// If the branch is taken, the PC is redirected to PC+4 + sext(offset)<<2 and
// fetch is flushed for FLUSH_CYCLES bubble cycles. Otherwise the PC
// advances by 4 each cycle unless fetch is stalled.
//
// Ports:
//   clk          clock, all state updates on rising edge
//   reset        synchronous active-high reset
//   stall        fetch stall request (holds PC when no redirect happens)
//   br_valid     a branch resolution is presented this cycle
//   br_ready     unit can accept a resolution (accept = br_valid & br_ready)
//   br_zero      ALU Zero flag, 1 means the branch is taken
//   br_pc_plus4  PC+4 of the branch instruction
//   br_offset    raw BEQ immediate (signed word offset)
//   pc           current fetch address
//   pc_plus4     pc + 4, wrapping modulo 2^WIDTH
//   fetch_valid  fetch at pc is valid this cycle
//   flush        kill younger in-flight instructions
//   misaligned   one-cycle pulse, taken target had nonzero low bits
//   taken_count  taken branches since reset, wraps at 2^16
//
// WIDTH must be at least 18 so the shifted offset fits before extension.
// ---------------------------------------------------------------------------
module pc_redirect_unit #(
  parameter int unsigned         WIDTH        = 32,
  parameter logic [WIDTH-1:0]    RESET_PC     = '0,
  parameter int unsigned         FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic             br_zero,
  input  logic [WIDTH-1:0] br_pc_plus4,
  input  logic [15:0]      br_offset,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             fetch_valid,
  output logic             flush,
  output logic             misaligned,
  output logic [15:0]      taken_count
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] offset_ext;
  logic [WIDTH-1:0] target;
  logic             accept;
  logic             take;

  // Offset is a word offset: shift left by two, then sign-extend to WIDTH.
  assign offset_ext = {{(WIDTH-18){br_offset[15]}}, br_offset, 2'b00};
  assign target     = br_pc_plus4 + offset_ext;

  assign pc_plus4   = pc + WIDTH'(4);

  // Handshake and fetch qualifiers are decoded from state; reset forces
  // them low immediately so nothing is fetched or accepted during reset.
  assign br_ready    = (state == RUN) && !reset;
  assign fetch_valid = (state == RUN) && !stall && !reset;
  assign flush       = (state == FLUSH);

  assign accept = br_valid && br_ready;
  assign take   = accept && br_zero;

  // Single state machine: PC update, bubble countdown, taken counter and the
  // misalignment pulse. A taken redirect wins over stall; the low target bits
  // are dropped so fetch always stays word aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      cnt         <= '0;
      misaligned  <= 1'b0;
      taken_count <= '0;
    end else begin
      misaligned <= 1'b0;
      case (state)
        RUN: begin
          if (take) begin
            pc          <= {target[WIDTH-1:2], 2'b00};
            taken_count <= taken_count + 16'd1;
            misaligned  <= |target[1:0];
            if (FLUSH_CYCLES > 0) begin
              cnt   <= 4'(FLUSH_CYCLES);
              state <= FLUSH;
            end
          end else if (!stall) begin
            pc <= pc_plus4;
          end
        end
        FLUSH: begin
          // Countdown ignores stall; the last flush cycle is the one with cnt==1.
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_redirect_unit
//
// Directed bench for pc_redirect_unit with default parameters
// (WIDTH=32, RESET_PC=0, FLUSH_CYCLES=2). Expected values are written out
// by hand for each step.
// ---------------------------------------------------------------------------
module tb_pc_redirect_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_valid;
  logic        br_ready;
  logic        br_zero;
  logic [31:0] br_pc_plus4;
  logic [15:0] br_offset;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush;
  logic        misaligned;
  logic [15:0] taken_count;

  int total;
  int bad;

  pc_redirect_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br_valid    (br_valid),
    .br_ready    (br_ready),
    .br_zero     (br_zero),
    .br_pc_plus4 (br_pc_plus4),
    .br_offset   (br_offset),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_valid (fetch_valid),
    .flush       (flush),
    .misaligned  (misaligned),
    .taken_count (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic zero,
                               input logic [31:0] pc4, input logic [15:0] off);
    br_valid    = valid;
    br_zero     = zero;
    br_pc_plus4 = pc4;
    br_offset   = off;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    stall = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0, 16'd0);

    // Reset held for two cycles.
    tick();
    tick();
    checkOutput("rst_pc", pc, 32'd0);
    checkOutput("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    checkOutput("rst_br_ready", {31'd0, br_ready}, 32'd0);
    checkOutput("rst_flush", {31'd0, flush}, 32'd0);
    checkOutput("rst_taken_count", {16'd0, taken_count}, 32'd0);

    // Release: pc walks 0, 4, 8.
    reset = 1'b0;
    #1;
    checkOutput("run_pc0", pc, 32'd0);
    checkOutput("run_fetch_valid", {31'd0, fetch_valid}, 32'd1);
    checkOutput("run_pc_plus4", pc_plus4, 32'd4);
    tick();
    checkOutput("run_pc4", pc, 32'd4);
    tick();
    checkOutput("run_pc8", pc, 32'd8);

    // Taken branch: 100 + (4<<2) = 116, two flush cycles.
    $display("[TB] taken branch");
    applyStimulus(1'b1, 1'b1, 32'd100, 16'd4);
    #1;
    checkOutput("tk_br_ready", {31'd0, br_ready}, 32'd1);
    tick();
    checkOutput("tk_pc", pc, 32'd116);
    checkOutput("tk_flush1", {31'd0, flush}, 32'd1);
    checkOutput("tk_fetch_valid1", {31'd0, fetch_valid}, 32'd0);
    checkOutput("tk_br_ready1", {31'd0, br_ready}, 32'd0);
    checkOutput("tk_count", {16'd0, taken_count}, 32'd1);
    checkOutput("tk_misaligned", {31'd0, misaligned}, 32'd0);
    // A branch presented during flush must be ignored.
    applyStimulus(1'b1, 1'b1, 32'd200, 16'd0);
    tick();
    checkOutput("tk_flush2", {31'd0, flush}, 32'd1);
    checkOutput("tk_pc_hold", pc, 32'd116);
    checkOutput("tk_ignore_count", {16'd0, taken_count}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'd0, 16'd0);
    tick();
    checkOutput("tk_flush_done", {31'd0, flush}, 32'd0);
    checkOutput("tk_fetch_target", {31'd0, fetch_valid}, 32'd1);
    checkOutput("tk_pc_target", pc, 32'd116);
    checkOutput("tk_pc_plus4", pc_plus4, 32'd120);
    tick();
    checkOutput("tk_pc_next", pc, 32'd120);

    // Not taken: sequential flow continues.
    $display("[TB] not taken branch");
    applyStimulus(1'b1, 1'b0, 32'd100, 16'd4);
    tick();
    checkOutput("nt_pc", pc, 32'd124);
    checkOutput("nt_flush", {31'd0, flush}, 32'd0);
    checkOutput("nt_count", {16'd0, taken_count}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'd0, 16'd0);
    tick();
    checkOutput("nt_pc_next", pc, 32'd128);

    // Negative offset: 100 - 4 = 96.
    $display("[TB] negative and wrapping targets");
    applyStimulus(1'b1, 1'b1, 32'd100, 16'hFFFF);
    tick();
    checkOutput("neg_pc", pc, 32'd96);
    checkOutput("neg_count", {16'd0, taken_count}, 32'd2);
    applyStimulus(1'b0, 1'b0, 32'd0, 16'd0);
    tick();
    tick();
    checkOutput("neg_fetch_valid", {31'd0, fetch_valid}, 32'd1);
    checkOutput("neg_pc_after", pc, 32'd96);
    // Wrap: FFFFFFFC + 4 = 0.
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 16'd1);
    tick();
    checkOutput("wrap_pc", pc, 32'd0);
    checkOutput("wrap_count", {16'd0, taken_count}, 32'd3);
    applyStimulus(1'b0, 1'b0, 32'd0, 16'd0);
    tick();
    tick();
    checkOutput("wrap_pc_plus4", pc_plus4, 32'd4);

    // Stall: redirect still wins, then pc holds while stalled.
    $display("[TB] stall versus redirect");
    stall = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'd100, 16'd4);
    #1;
    checkOutput("st_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    tick();
    checkOutput("st_redirect_pc", pc, 32'd116);
    checkOutput("st_count", {16'd0, taken_count}, 32'd4);
    applyStimulus(1'b0, 1'b0, 32'd0, 16'd0);
    tick();
    tick();
    checkOutput("st_flush_end", {31'd0, flush}, 32'd0);
    tick();
    checkOutput("st_hold1", pc, 32'd116);
    tick();
    checkOutput("st_hold2", pc, 32'd116);
    tick();
    checkOutput("st_hold3", pc, 32'd116);
    stall = 1'b0;
    tick();
    checkOutput("st_release", pc, 32'd120);

    // Reset during the first flush cycle.
    $display("[TB] reset mid-flush and misaligned target");
    applyStimulus(1'b1, 1'b1, 32'd100, 16'd4);
    tick();
    checkOutput("rf_flush", {31'd0, flush}, 32'd1);
    checkOutput("rf_count5", {16'd0, taken_count}, 32'd5);
    applyStimulus(1'b0, 1'b0, 32'd0, 16'd0);
    reset = 1'b1;
    tick();
    checkOutput("rf_pc", pc, 32'd0);
    checkOutput("rf_flush_cleared", {31'd0, flush}, 32'd0);
    checkOutput("rf_count_cleared", {16'd0, taken_count}, 32'd0);
    reset = 1'b0;
    // 102 + 16 = 118: low bits dropped, one-cycle misaligned pulse.
    applyStimulus(1'b1, 1'b1, 32'd102, 16'd4);
    tick();
    checkOutput("ma_pc", pc, 32'd116);
    checkOutput("ma_pulse", {31'd0, misaligned}, 32'd1);
    checkOutput("ma_count", {16'd0, taken_count}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'd0, 16'd0);
    tick();
    checkOutput("ma_pulse_end", {31'd0, misaligned}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
